shift_secuencial_ctrl: RTL and testbench

Multi-cycle shift sequencer for area-constrained builds of the ALU.
- Produces the same results as the combinational shift unit (SLL/SRL/SRA), but applies at most PASO bit positions per clock.
- Uses a start/busy/done handshake towards the control unit.
- Latches operands on start and holds the result until the next accepted start.

---
 rtl/shift_secuencial_ctrl.sv | 139 +++++++++++++
 tb/tb_shift_secuencial_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_secuencial_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer, at most PASO bit positions per clock, start/busy/done handshake.
// Define SHIFT_ROTATE_EN to turn operation code 11 into rotate-right; otherwise 11 flags error_o.
//
// state    | meaning
// ST_IDLE  | waiting for inicio_i, salida_o holds the last result
// ST_SHIFT | working register shifted by min(PASO, cnt) each clock
// ST_DONE  | one cycle, listo_o high with salida_o valid
module shift_secuencial_ctrl #(
   parameter int N    = 16,
   parameter int PASO = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inicio_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [1:0]   operacion_i,
   output logic         ocupado_o,
   output logic         listo_o,
   output logic         error_o,
   output logic [N-1:0] salida_o
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LP_N_CNT = CW'(N);
   localparam logic [CW-1:0] LP_PASO  = CW'(PASO);
   localparam logic [N-1:0]  LP_N_VEC = N'(N);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t        r_state, w_state_next;
   logic [N-1:0]  r_work, w_work_next;
   logic [N-1:0]  r_salida, w_salida_next;
   logic [CW-1:0] r_cnt, w_cnt_next;
   logic [1:0]    r_op, w_op_next;
   logic [CW-1:0] w_cnt_ini, w_step, w_cnt_rest;
   logic [N-1:0]  w_shifted;
   logic          w_op_in_bad;

   // Amount latched on start: saturated to N, except rotate (mod N) and unsupported codes (0).
   always_comb begin
      w_cnt_ini   = (b_i >= LP_N_VEC) ? LP_N_CNT : CW'(b_i);
      w_op_in_bad = 1'b0;
`ifdef SHIFT_ROTATE_EN
      if (operacion_i == 2'b11) begin
         w_cnt_ini = CW'(b_i % LP_N_VEC);
      end
`else
      if (operacion_i == 2'b11) begin
         w_cnt_ini   = '0;
         w_op_in_bad = 1'b1;
      end
`endif
   end

   assign w_step     = (r_cnt < LP_PASO) ? r_cnt : LP_PASO;
   assign w_cnt_rest = r_cnt - w_step;

   // The working register MSB stays equal to the latched sign under SRA, so >>> replicates it.
   always_comb begin
      w_shifted = r_work;
      case (r_op)
         2'b00:   w_shifted = r_work << w_step;
         2'b01:   w_shifted = r_work >> w_step;
         2'b10:   w_shifted = $signed(r_work) >>> w_step;
`ifdef SHIFT_ROTATE_EN
         2'b11:   w_shifted = (r_work >> w_step) | (r_work << (LP_N_CNT - w_step));
`endif
         default: w_shifted = r_work;
      endcase
   end

   always_comb begin
      w_state_next  = r_state;
      w_work_next   = r_work;
      w_cnt_next    = r_cnt;
      w_op_next     = r_op;
      w_salida_next = r_salida;
      case (r_state)
         ST_IDLE: begin
            if (inicio_i) begin
               w_work_next = a_i;
               w_op_next   = operacion_i;
               w_cnt_next  = w_cnt_ini;
               if (w_cnt_ini != '0) begin
                  w_state_next = ST_SHIFT;
               end else begin
                  w_state_next  = ST_DONE;
                  w_salida_next = w_op_in_bad ? '0 : a_i;
               end
            end
         end
         ST_SHIFT: begin
            w_work_next = w_shifted;
            w_cnt_next  = w_cnt_rest;
            if (w_cnt_rest == '0) begin
               w_state_next  = ST_DONE;
               w_salida_next = w_shifted;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_work   <= '0;
         r_salida <= '0;
         r_cnt    <= '0;
         r_op     <= '0;
      end else begin
         r_state  <= w_state_next;
         r_work   <= w_work_next;
         r_salida <= w_salida_next;
         r_cnt    <= w_cnt_next;
         r_op     <= w_op_next;
      end
   end

   assign ocupado_o = (r_state != ST_IDLE);
   assign listo_o   = (r_state == ST_DONE);
   assign salida_o  = r_salida;
`ifdef SHIFT_ROTATE_EN
   assign error_o   = 1'b0;
`else
   assign error_o   = (r_state == ST_DONE) && (r_op == 2'b11);
`endif

endmodule

// File: tb/tb_shift_secuencial_ctrl.sv
// Bench for shift_secuencial_ctrl: PASO=1 and PASO=4 instances share stimulus, checked against an arithmetic model.
// Follows SHIFT_ROTATE_EN the same way the design does.
module tb_shift_secuencial_ctrl;

   localparam int N  = 16;
   localparam int PA = 1;
   localparam int PB = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         inicio;
   logic [N-1:0] a, b;
   logic [1:0]   op;
   logic         ocup [2];
   logic         listo [2];
   logic         err [2];
   logic [N-1:0] sal [2];

   int n_vec  = 0;
   int n_fail = 0;

   shift_secuencial_ctrl #(.N(N), .PASO(PA)) u_p1 (
      .clk_i(clk), .rst_i(rst), .inicio_i(inicio), .a_i(a), .b_i(b), .operacion_i(op),
      .ocupado_o(ocup[0]), .listo_o(listo[0]), .error_o(err[0]), .salida_o(sal[0])
   );

   shift_secuencial_ctrl #(.N(N), .PASO(PB)) u_p4 (
      .clk_i(clk), .rst_i(rst), .inicio_i(inicio), .a_i(a), .b_i(b), .operacion_i(op),
      .ocupado_o(ocup[1]), .listo_o(listo[1]), .error_o(err[1]), .salida_o(sal[1])
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_cnt(input logic [N-1:0] bb, input logic [1:0] oo);
      int amt;
      amt = int'(bb);
      if (oo == 2'b11) begin
`ifdef SHIFT_ROTATE_EN
         return amt % N;
`else
         return 0;
`endif
      end
      return (amt >= N) ? N : amt;
   endfunction

   function automatic logic [N-1:0] ref_res(input logic [N-1:0] aa, input logic [N-1:0] bb,
                                            input logic [1:0] oo);
      int           amt;
      logic [N-1:0] ones;
      logic [N-1:0] fill;
      logic [2*N-1:0] dbl;
      amt  = int'(bb);
      ones = '1;
      case (oo)
         2'd0: return (amt >= N) ? '0 : (aa << amt);
         2'd1: return (amt >= N) ? '0 : (aa >> amt);
         2'd2: begin
            fill = aa[N-1] ? ((amt >= N) ? ones : ~(ones >> amt)) : '0;
            return ((amt >= N) ? '0 : (aa >> amt)) | fill;
         end
         default: begin
`ifdef SHIFT_ROTATE_EN
            dbl = {aa, aa} >> (amt % N);
            return dbl[N-1:0];
`else
            dbl = '0;
            return dbl[N-1:0];
`endif
         end
      endcase
   endfunction

   function automatic logic ref_err(input logic [1:0] oo);
`ifdef SHIFT_ROTATE_EN
      return 1'b0;
`else
      return (oo == 2'b11);
`endif
   endfunction

   // Starts one operation at the current negedge and follows both instances to completion.
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic [1:0] top,
                         input int reissue_at);
      int           exp_lat [2];
      int           lat [2];
      int           busy [2];
      bit           done [2];
      logic [N-1:0] res [2];
      logic         e [2];
      logic [N-1:0] exp_res;
      logic         exp_err;
      int           c;
      exp_res    = ref_res(ta, tb, top);
      exp_err    = ref_err(top);
      c          = ref_cnt(tb, top);
      exp_lat[0] = (c + PA - 1) / PA + 1;
      exp_lat[1] = (c + PB - 1) / PB + 1;
      for (int d = 0; d < 2; d++) begin
         lat[d] = 0; busy[d] = 0; done[d] = 1'b0; res[d] = '0; e[d] = 1'b0;
      end
      a = ta; b = tb; op = top; inicio = 1'b1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!done[d]) begin
               if (ocup[d]) busy[d]++;
               if (listo[d]) begin
                  done[d] = 1'b1; lat[d] = j; res[d] = sal[d]; e[d] = err[d];
               end
            end
         end
         if (done[0] && done[1]) begin
            inicio = 1'b0;
            break;
         end
         if (j == reissue_at) begin
            inicio = 1'b1; a = '1; b = 16'd1; op = 2'b01;
         end else begin
            inicio = 1'b0; a = N'($urandom); b = N'($urandom); op = 2'($urandom);
         end
      end
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("done_p%0d", d), 32'(done[d]), 32'd1);
         chk($sformatf("latency_p%0d", d), lat[d], exp_lat[d]);
         chk($sformatf("busy_cycles_p%0d", d), busy[d], exp_lat[d]);
         chk($sformatf("result_p%0d a=%0h b=%0h op=%0d", d, ta, tb, top), 32'(res[d]), 32'(exp_res));
         chk($sformatf("error_p%0d", d), 32'(e[d]), 32'(exp_err));
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("listo_pulse_p%0d", d), 32'(listo[d]), 32'd0);
         chk($sformatf("idle_p%0d", d), 32'(ocup[d]), 32'd0);
         chk($sformatf("error_low_p%0d", d), 32'(err[d]), 32'd0);
         chk($sformatf("hold_p%0d", d), 32'(sal[d]), 32'(exp_res));
      end
   endtask

   initial begin
      int lcount;
      logic [N-1:0] ra, rb;
      logic [1:0]   rop;
      rst = 1'b1; inicio = 1'b0; a = '0; b = '0; op = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_salida_p%0d", d), 32'(sal[d]), 32'd0);
         chk($sformatf("rst_ocupado_p%0d", d), 32'(ocup[d]), 32'd0);
         chk($sformatf("rst_listo_p%0d", d), 32'(listo[d]), 32'd0);
         chk($sformatf("rst_error_p%0d", d), 32'(err[d]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      run_op(16'h0001, 16'd4, 2'b00, 0);
      run_op(16'h8000, 16'd3, 2'b10, 0);
      run_op(16'h8000, 16'd3, 2'b01, 0);
      run_op(16'hFFFF, 16'd20, 2'b01, 0);
      run_op(16'h8001, 16'hFFFF, 2'b10, 0);
      run_op(16'h8001, 16'd16, 2'b00, 0);
      for (int k = 0; k < 4; k++) run_op(16'h1234, 16'd0, 2'(k), 0);
      run_op(16'h0001, 16'd6, 2'b00, 0);
      run_op(16'h0001, 16'd17, 2'b11, 0);
      run_op(16'hC3A5, 16'd5, 2'b11, 0);
      run_op(16'h0003, 16'd8, 2'b00, 2);

      // Reset in the middle of an operation.
      a = 16'h0003; b = 16'd8; op = 2'b00; inicio = 1'b1;
      @(negedge clk); inicio = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_before_rst", 32'(ocup[0]), 32'd1);
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("midrst_salida_p%0d", d), 32'(sal[d]), 32'd0);
         chk($sformatf("midrst_ocupado_p%0d", d), 32'(ocup[d]), 32'd0);
         chk($sformatf("midrst_listo_p%0d", d), 32'(listo[d]), 32'd0);
      end
      @(negedge clk); rst = 1'b0;
      lcount = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (listo[0] || listo[1] || ocup[0] || ocup[1]) lcount++;
      end
      chk("no_activity_after_rst", lcount, 0);
      run_op(16'h00F0, 16'd2, 2'b01, 0);

      for (int k = 0; k < 40; k++) begin
         ra  = N'($urandom);
         rb  = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, N + 2));
         rop = 2'($urandom_range(0, 3));
         run_op(ra, rb, rop, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
